// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and header field layout for the router ingress arbiter
package router_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP,
        DROP,
        FLUSH
    } state_t;

    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int         LEN_MSB      = 7;
    localparam int         LEN_LSB      = 2;
    localparam int         ADDR_W       = 2;
    localparam int         MAX_LEN      = 63;

    function automatic logic [LEN_MSB-LEN_LSB:0] hdr_len(input logic [7:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
        return hdr[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot round-robin pick with a registered last-owner pointer
module rr_arbiter #(
    parameter int NUM_SRC = 3
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NUM_SRC-1:0] req,
    input  logic               advance,
    output logic [NUM_SRC-1:0] gnt
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [IDX_W-1:0]   last;
    logic [NUM_SRC-1:0] hi_sel;
    logic [NUM_SRC-1:0] lo_sel;

    // Requesters above the last owner beat those at or below it; lowest index wins in each half.
    always_comb begin
        hi_sel = '0;
        lo_sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(last)) begin
                    hi_sel    = '0;
                    hi_sel[i] = 1'b1;
                end else begin
                    lo_sel    = '0;
                    lo_sel[i] = 1'b1;
                end
            end
        end
        gnt = (hi_sel != '0) ? hi_sel : lo_sel;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last <= IDX_W'(NUM_SRC - 1);
        end else if (advance) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (gnt[i]) last <= IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/router_ingress_arbiter.sv
// rtl/router_ingress_arbiter.sv - packet-level round-robin sharing of the router input port
module router_ingress_arbiter
    import router_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_ready,
    input  logic                 rtr_busy,
    output logic [7:0]           rtr_data_in,
    output logic                 rtr_pkt_valid,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 pkt_sent,
    output logic                 pkt_drop,
    output logic [NUM_SRC-1:0]   underrun,
    input  logic                 underrun_clr
);

    localparam int         RTR_CNT_W = $clog2(MAX_LEN + 1);
    localparam int         SRC_CNT_W = $clog2(MAX_LEN + 2);
    localparam logic [3:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam state_t     AFTER_PKT = (GAP_CYCLES > 0) ? GAP : IDLE;

    state_t                 state;
    logic [7:0]             hdr;
    logic [7:0]             parity;
    logic [RTR_CNT_W-1:0]   rtr_cnt;
    logic [SRC_CNT_W-1:0]   src_cnt;
    logic [3:0]             gap_cnt;
    logic                   poisoned;

    logic [NUM_SRC-1:0]     pick;
    logic [7:0]             pick_data;
    logic [7:0]             g_data;
    logic                   g_valid;
    logic [7:0]             pay_byte;
    logic                   rdy_g;
    logic                   consume;
    logic [NUM_SRC-1:0]     ur_set;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .clock   (clock),
        .resetn  (resetn),
        .req     (src_valid),
        .advance ((state == IDLE) && (|src_valid)),
        .gnt     (pick)
    );

    always_comb begin
        g_data    = '0;
        g_valid   = 1'b0;
        pick_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                g_data  = src_data[8*i +: 8];
                g_valid = src_valid[i];
            end
            if (pick[i]) pick_data = src_data[8*i +: 8];
        end
    end

    // A missing payload byte, and everything after it, goes to the router as zero.
    assign pay_byte = (poisoned || !g_valid) ? 8'h00 : g_data;

    always_comb begin
        rdy_g = 1'b0;
        case (state)
            HEADER:  rdy_g = !rtr_busy;
            PAYLOAD: rdy_g = poisoned ? (g_valid && (src_cnt != '0)) : !rtr_busy;
            FLUSH:   rdy_g = g_valid;
            DROP:    rdy_g = g_valid;
            default: rdy_g = 1'b0;
        endcase
    end

    assign src_ready = grant & {NUM_SRC{rdy_g}};
    assign consume   = g_valid && rdy_g;

    always_comb begin
        rtr_data_in = 8'h00;
        case (state)
            HEADER:  rtr_data_in = hdr;
            PAYLOAD: rtr_data_in = pay_byte;
            PARITY:  rtr_data_in = poisoned ? ~parity : parity;
            default: rtr_data_in = 8'h00;
        endcase
    end

    assign rtr_pkt_valid = (state == HEADER) || (state == PAYLOAD);
    assign ur_set = (state == PAYLOAD && !rtr_busy && !poisoned && !g_valid) ? grant : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            grant    <= '0;
            hdr      <= '0;
            parity   <= '0;
            rtr_cnt  <= '0;
            src_cnt  <= '0;
            gap_cnt  <= '0;
            poisoned <= 1'b0;
            pkt_sent <= 1'b0;
            pkt_drop <= 1'b0;
        end else begin
            pkt_sent <= 1'b0;
            pkt_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (|src_valid) begin
                        grant    <= pick;
                        hdr      <= pick_data;
                        poisoned <= 1'b0;
                        if (hdr_addr(pick_data) == ADDR_INVALID) begin
                            src_cnt <= SRC_CNT_W'(hdr_len(pick_data)) + SRC_CNT_W'(1);
                            state   <= DROP;
                        end else begin
                            state   <= HEADER;
                        end
                    end
                end
                HEADER: begin
                    if (!rtr_busy) begin
                        parity  <= hdr;
                        rtr_cnt <= RTR_CNT_W'(hdr_len(hdr));
                        src_cnt <= SRC_CNT_W'(hdr_len(hdr));
                        state   <= (hdr_len(hdr) == 6'd0) ? PARITY : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (consume) src_cnt <= src_cnt - SRC_CNT_W'(1);
                    if (!rtr_busy) begin
                        parity  <= parity ^ pay_byte;
                        rtr_cnt <= rtr_cnt - RTR_CNT_W'(1);
                        if (!g_valid) poisoned <= 1'b1;
                        if (rtr_cnt == RTR_CNT_W'(1)) state <= PARITY;
                    end
                end
                PARITY: begin
                    if (!rtr_busy) begin
                        pkt_sent <= 1'b1;
                        if (src_cnt != '0) begin
                            state <= FLUSH;
                        end else begin
                            state   <= AFTER_PKT;
                            grant   <= '0;
                            gap_cnt <= GAP_LOAD;
                        end
                    end
                end
                FLUSH: begin
                    if (consume) begin
                        src_cnt <= src_cnt - SRC_CNT_W'(1);
                        if (src_cnt == SRC_CNT_W'(1)) begin
                            state   <= AFTER_PKT;
                            grant   <= '0;
                            gap_cnt <= GAP_LOAD;
                        end
                    end
                end
                DROP: begin
                    if (consume) begin
                        src_cnt <= src_cnt - SRC_CNT_W'(1);
                        if (src_cnt == SRC_CNT_W'(1)) begin
                            pkt_drop <= 1'b1;
                            state    <= IDLE;
                            grant    <= '0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Set beats clear when both land on the same edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) underrun <= '0;
        else         underrun <= (underrun_clr ? '0 : underrun) | ur_set;
    end

endmodule

// File: tb/tb_router_ingress_arbiter.sv
// tb/tb_router_ingress_arbiter.sv - randomized self-checking bench for router_ingress_arbiter
module tb_router_ingress_arbiter;

    localparam int NS  = 3;
    localparam int GAP = 2;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic [NS-1:0]   src_valid;
    logic [8*NS-1:0] src_data;
    logic [NS-1:0]   src_ready;
    logic            rtr_busy;
    logic [7:0]      rtr_data_in;
    logic            rtr_pkt_valid;
    logic [NS-1:0]   grant;
    logic            pkt_sent;
    logic            pkt_drop;
    logic [NS-1:0]   underrun;
    logic            underrun_clr;

    router_ingress_arbiter #(.NUM_SRC(NS), .GAP_CYCLES(GAP)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_ready     (src_ready),
        .rtr_busy      (rtr_busy),
        .rtr_data_in   (rtr_data_in),
        .rtr_pkt_valid (rtr_pkt_valid),
        .grant         (grant),
        .pkt_sent      (pkt_sent),
        .pkt_drop      (pkt_drop),
        .underrun      (underrun),
        .underrun_clr  (underrun_clr)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [7:0] srcq[NS][$];
    logic [7:0] mq[NS][$];
    logic [8:0] exp_bytes[$];
    int         exp_grant[$];
    int         m_last = NS - 1;
    int         exp_sent = 0, exp_drop = 0, got_sent = 0, got_drop = 0;
    int         cons_cnt[NS];
    bit         in_pkt = 0;
    int         pkt_bytes = 0;
    int         cyc = 0;
    int         last_par_cyc = -1;
    bit         chk_gap = 0;
    bit         busy_rand = 0;
    int         busy_at = -1, busy_left = 0;
    int         hold_src = -1, hold_sz = 0, hold_left = 0;
    logic [NS-1:0] prev_grant = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_pkt(input int s, input logic [7:0] hdr);
        logic [7:0] b;
        srcq[s].push_back(hdr);
        mq[s].push_back(hdr);
        for (int k = 0; k < int'(hdr[7:2]); k++) begin
            b = 8'($urandom);
            srcq[s].push_back(b);
            mq[s].push_back(b);
        end
    endtask

    // Round-robin over sources holding packets; addr 3 is dropped, others framed with XOR parity.
    task automatic model_run();
        int s;
        int len;
        bit more;
        logic [7:0] h, b, par;
        more = 1;
        while (more) begin
            s = -1;
            for (int k = 1; k <= NS; k++)
                if (s < 0 && mq[(m_last + k) % NS].size() != 0) s = (m_last + k) % NS;
            if (s < 0) begin
                more = 0;
            end else begin
                h   = mq[s].pop_front();
                len = int'(h[7:2]);
                par = h;
                exp_grant.push_back(s);
                if (h[1:0] == 2'b11) begin
                    repeat (len) void'(mq[s].pop_front());
                    exp_drop++;
                end else begin
                    exp_bytes.push_back({1'b1, h});
                    repeat (len) begin
                        b = mq[s].pop_front();
                        par ^= b;
                        exp_bytes.push_back({1'b1, b});
                    end
                    exp_bytes.push_back({1'b0, par});
                    exp_sent++;
                end
                m_last = s;
            end
        end
    endtask

    task automatic step();
        logic [8:0] rb;
        bit forced;
        @(negedge clock);
        for (int i = 0; i < NS; i++) begin
            src_valid[i] = (srcq[i].size() != 0);
            if (i == hold_src && srcq[i].size() == hold_sz && hold_left > 0) begin
                src_valid[i] = 1'b0;
                hold_left--;
            end
            src_data[8*i +: 8] = src_valid[i] ? srcq[i][0] : 8'($urandom);
        end
        forced = (busy_left > 0 && in_pkt && pkt_bytes == busy_at);
        if (forced) begin
            rtr_busy = 1'b1;
            busy_left--;
        end else begin
            rtr_busy = busy_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        #1;
        if (forced) begin
            check("busy_rdy", 32'(src_ready), 32'(0));
            check("busy_hold", 32'({rtr_pkt_valid, rtr_data_in}), 32'(exp_bytes[0]));
        end
        for (int i = 0; i < NS; i++) begin
            if (src_valid[i] && src_ready[i]) begin
                void'(srcq[i].pop_front());
                cons_cnt[i]++;
            end
        end
        if (!rtr_busy && (rtr_pkt_valid || in_pkt)) begin
            rb = {rtr_pkt_valid, rtr_data_in};
            if (exp_bytes.size() != 0) check("rtr_byte", 32'(rb), 32'(exp_bytes.pop_front()));
            else                       check("rtr_extra", 32'(rb), 32'hDEAD);
            if (rtr_pkt_valid && !in_pkt) begin
                if (chk_gap && last_par_cyc >= 0) check("gap", 32'(cyc - last_par_cyc), 32'(2 + GAP));
                in_pkt    = 1;
                pkt_bytes = 1;
            end else if (rtr_pkt_valid) begin
                pkt_bytes++;
            end else begin
                in_pkt       = 0;
                pkt_bytes    = 0;
                last_par_cyc = cyc;
            end
        end
        if (pkt_sent) got_sent++;
        if (pkt_drop) got_drop++;
        if (grant != '0 && prev_grant == '0) begin
            if (exp_grant.size() != 0) check("grant", 32'(grant), 32'(1 << exp_grant.pop_front()));
            else                       check("grant_extra", 32'(grant), 32'(0));
        end
        prev_grant = grant;
        cyc++;
    endtask

    task automatic run_until_done(input int budget);
        int n;
        int idle;
        bit empty;
        n = 0;
        idle = 0;
        while (idle < 6 && n < budget) begin
            step();
            n++;
            empty = (exp_bytes.size() == 0) && (grant == '0);
            for (int i = 0; i < NS; i++) if (srcq[i].size() != 0) empty = 0;
            idle = empty ? idle + 1 : 0;
        end
        check("timeout", 32'(n < budget), 32'(1));
        check("sent_cnt", 32'(got_sent), 32'(exp_sent));
        check("drop_cnt", 32'(got_drop), 32'(exp_drop));
        check("grant_left", 32'(exp_grant.size()), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] h, b, par;
        src_valid    = '0;
        src_data     = '0;
        rtr_busy     = 1'b0;
        underrun_clr = 1'b0;
        for (int i = 0; i < NS; i++) cons_cnt[i] = 0;
        repeat (3) @(negedge clock);
        #1;
        check("reset_outs", 32'({src_ready, rtr_data_in, rtr_pkt_valid, grant, pkt_sent, pkt_drop, underrun}), 32'(0));
        resetn = 1'b1;

        // three continuous requesters, length 2: order 0,1,2,0,1,2 and fixed gap
        chk_gap = 1;
        last_par_cyc = -1;
        for (int s = 0; s < NS; s++) begin
            load_pkt(s, 8'h08);
            load_pkt(s, 8'h08);
        end
        model_run();
        run_until_done(400);
        chk_gap = 0;

        // single packet 0x21 from source 0
        cons_cnt[0] = 0;
        load_pkt(0, 8'h21);
        model_run();
        run_until_done(200);
        check("t1_cons", 32'(cons_cnt[0]), 32'(9));

        // busy held on payload byte 4
        busy_at = 4;
        busy_left = 3;
        load_pkt(0, 8'h21);
        model_run();
        run_until_done(200);
        check("busy_inj", 32'(busy_left), 32'(0));
        busy_at = -1;

        // invalid address drained, pointer moves past source 2
        load_pkt(1, 8'h04);
        model_run();
        run_until_done(200);
        cons_cnt[2] = 0;
        load_pkt(2, 8'h0F);
        load_pkt(0, 8'h05);
        load_pkt(1, 8'h09);
        model_run();
        run_until_done(400);
        check("drop_cons", 32'(cons_cnt[2]), 32'(4));

        // underrun on payload byte 2 of a length-5 packet from source 1
        cons_cnt[1] = 0;
        hold_src = 1;
        hold_sz = 4;
        hold_left = 2;
        load_pkt(1, 8'h15);
        h = mq[1].pop_front();
        par = h;
        exp_bytes.push_back({1'b1, h});
        for (int k = 1; k <= 5; k++) begin
            b = mq[1].pop_front();
            if (k < 2) begin
                par ^= b;
                exp_bytes.push_back({1'b1, b});
            end else begin
                exp_bytes.push_back(9'h100);
            end
        end
        exp_bytes.push_back({1'b0, ~par});
        exp_grant.push_back(1);
        m_last = 1;
        exp_sent++;
        run_until_done(300);
        check("ur_cons", 32'(cons_cnt[1]), 32'(6));
        check("ur_flag", 32'(underrun), 32'(3'b010));
        hold_src = -1;
        step();
        check("ur_sticky", 32'(underrun), 32'(3'b010));
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        step();
        check("ur_clr", 32'(underrun), 32'(0));

        // reset in the middle of a payload
        load_pkt(0, 8'h21);
        model_run();
        for (int n = 0; n < 60 && pkt_bytes < 3; n++) step();
        check("rst_reach", 32'(pkt_bytes >= 3), 32'(1));
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("rst_async", 32'({src_ready, rtr_data_in, rtr_pkt_valid, grant, pkt_sent, pkt_drop, underrun}), 32'(0));
        for (int i = 0; i < NS; i++) begin
            srcq[i].delete();
            mq[i].delete();
        end
        exp_bytes.delete();
        exp_grant.delete();
        exp_sent   = got_sent;
        exp_drop   = got_drop;
        m_last     = NS - 1;
        in_pkt     = 0;
        pkt_bytes  = 0;
        prev_grant = '0;
        step();
        step();
        resetn = 1'b1;
        for (int s = NS - 1; s >= 0; s--) load_pkt(s, 8'h0C);
        model_run();
        run_until_done(400);

        // randomized traffic with random busy and random invalid addresses
        busy_rand = 1;
        for (int r = 0; r < 8; r++) begin
            for (int s = 0; s < NS; s++)
                repeat ($urandom_range(0, 2))
                    load_pkt(s, {6'($urandom_range(0, 10)), 2'($urandom_range(0, 3))});
            model_run();
            run_until_done(3000);
        end
        busy_rand = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
